// File: rtl/sxafa_macro_if.sv
// Bus bundle for the sxafa_macro bit array: write data, row enables, compute operand
// and the registered column result.
interface sxafa_macro_if #(
    parameter int ROWS = 128,
    parameter int COLS = 64
);
    logic            WE;
    logic [COLS-1:0] BL;
    logic [COLS-1:0] BLB;
    logic            Addr;
    logic [ROWS-1:0] WL;
    logic [ROWS-1:0] In_B;
    logic            wb;
    logic [COLS-1:0] DOut;

    modport master (
        output WE, BL, BLB, Addr, WL, In_B, wb,
        input  DOut
    );

    modport slave (
        input  WE, BL, BLB, Addr, WL, In_B, wb,
        output DOut
    );
endinterface

// File: rtl/sxafa_macro.sv
// 128x64 bit array with multi-row differential write, wired-OR read and a per-column
// GF(2) dot product against a row operand; one-cycle registered result.
module sxafa_macro #(
    parameter int ROWS = 128,
    parameter int COLS = 64
) (
    input  logic          Clk,
    input  logic          Rst,
    sxafa_macro_if.slave  bus
);

    logic [COLS-1:0] cell_q [ROWS];
    logic [COLS-1:0] cell_d [ROWS];
    logic [COLS-1:0] dout_q;
    logic [COLS-1:0] dout_d;
    logic [COLS-1:0] or_acc;
    logic [COLS-1:0] xor_acc;

    // Differential write: BL=1/BLB=0 sets, BL=0/BLB=1 clears, equal lines leave the cell alone.
    function automatic logic [COLS-1:0] bitline_write(
        input logic [COLS-1:0] cur,
        input logic [COLS-1:0] bl,
        input logic [COLS-1:0] blb
    );
        return (cur & ~(blb & ~bl)) | (bl & ~blb);
    endfunction

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            cell_d[r] = cell_q[r];
            if (bus.WE && bus.WL[r]) begin
                cell_d[r] = bitline_write(cell_q[r], bus.BL, bus.BLB);
            end
        end
    end

    // Both reductions see the array as it stands before the edge.
    always_comb begin
        or_acc  = '0;
        xor_acc = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (bus.WL[r]) begin
                or_acc = or_acc | cell_q[r];
                if (bus.In_B[r]) begin
                    xor_acc = xor_acc ^ cell_q[r];
                end
            end
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (!bus.WE && bus.wb) begin
            dout_d = bus.Addr ? xor_acc : or_acc;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int r = 0; r < ROWS; r++) begin
                cell_q[r] <= '0;
            end
            dout_q <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                cell_q[r] <= cell_d[r];
            end
            dout_q <= dout_d;
        end
    end

    assign bus.DOut = dout_q;

endmodule

// File: tb/tb_sxafa_macro.sv
// Directed bench for sxafa_macro: reset, full/selective write, read, compute, hold
// and mid-burst reset, with hand-computed expectations.
module tb_sxafa_macro;

    logic Clk;
    logic Rst;
    int   vectors;
    int   miscompares;

    sxafa_macro_if bus ();

    sxafa_macro dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    localparam logic [63:0]  ONES64  = {64{1'b1}};
    localparam logic [127:0] ONES128 = {128{1'b1}};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return on the falling edge for sampling/driving.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic set_idle();
        bus.WE   = 1'b0;
        bus.BL   = '0;
        bus.BLB  = '0;
        bus.Addr = 1'b0;
        bus.WL   = '0;
        bus.In_B = '0;
        bus.wb   = 1'b0;
    endtask

    task automatic do_write(input logic [127:0] wl, input logic [63:0] bl, input logic [63:0] blb);
        bus.WE  = 1'b1;
        bus.wb  = 1'b1;
        bus.WL  = wl;
        bus.BL  = bl;
        bus.BLB = blb;
        tick();
    endtask

    task automatic do_read(input logic [127:0] wl, input logic addr, input logic [127:0] inb);
        bus.WE   = 1'b0;
        bus.wb   = 1'b1;
        bus.WL   = wl;
        bus.Addr = addr;
        bus.In_B = inb;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        set_idle();
        Rst = 1'b0;
        #1;
        check("reset_dout", bus.DOut, 64'h0);
        @(negedge Clk);
        Rst = 1'b1;

        do_read(ONES128, 1'b0, '0);
        check("read_after_reset", bus.DOut, 64'h0);

        // Full write; DOut must hold during the write cycle.
        do_write(ONES128, ONES64, 64'h0);
        check("hold_during_write", bus.DOut, 64'h0);
        do_read(ONES128, 1'b0, '0);
        check("full_read", bus.DOut, ONES64);

        do_read(ONES128, 1'b1, 128'h1);
        check("compute_one_row", bus.DOut, ONES64);
        do_read(ONES128, 1'b1, 128'h3);
        check("compute_two_rows", bus.DOut, 64'h0);
        do_read(ONES128, 1'b1, 128'h8000_00FF_FFFF_FFFF_FFFF_FFFF_FFFF_F000);
        check("compute_odd_rows", bus.DOut, ONES64);
        do_read(ONES128, 1'b1, ONES128);
        check("compute_all_rows_even", bus.DOut, 64'h0);
        do_read(ONES128, 1'b0, 128'h3);
        check("read_ignores_inb", bus.DOut, ONES64);

        // Undriven bit lines leave cells alone.
        do_write(ONES128, ONES64, ONES64);
        do_read(ONES128, 1'b0, '0);
        check("no_drive_write", bus.DOut, ONES64);

        // wb=0 holds DOut even though the selected compute would give 0.
        bus.WE = 1'b0; bus.wb = 1'b0; bus.Addr = 1'b1; bus.In_B = 128'h3; bus.WL = ONES128;
        tick();
        tick();
        check("hold_wb0", bus.DOut, ONES64);
        do_read('0, 1'b0, '0);
        check("read_no_wl", bus.DOut, 64'h0);

        // Asynchronous reset between edges clears everything.
        Rst = 1'b0;
        #1;
        check("async_reset_mid", bus.DOut, 64'h0);
        Rst = 1'b1;
        do_read(ONES128, 1'b0, '0);
        check("array_cleared", bus.DOut, 64'h0);

        do_write(128'h4, 64'hA5, ~64'hA5);
        do_read(128'h4, 1'b0, '0);
        check("sel_read_row2", bus.DOut, 64'hA5);
        do_read(128'h1, 1'b0, '0);
        check("sel_read_row0", bus.DOut, 64'h0);
        do_read(128'h4, 1'b1, 128'h4);
        check("sel_compute_row2", bus.DOut, 64'hA5);
        do_read(128'h4, 1'b1, 128'h0);
        check("sel_compute_inb0", bus.DOut, 64'h0);

        // Bit lines are ignored while WE=0.
        bus.BL = ONES64; bus.BLB = '0;
        do_read(128'h4, 1'b0, '0);
        check("bl_ignored_read", bus.DOut, 64'hA5);
        do_read(128'h4, 1'b0, '0);
        check("bl_ignored_after", bus.DOut, 64'hA5);

        // Partial clear of bit 0 on row 2, other columns undriven.
        do_write(128'h4, 64'h0, 64'h1);
        do_read(ONES128, 1'b0, '0);
        check("partial_clear", bus.DOut, 64'hA4);

        // Reset in the middle of a write burst; edges under reset are ignored.
        bus.WE = 1'b1; bus.WL = ONES128; bus.BL = ONES64; bus.BLB = '0; bus.wb = 1'b1;
        @(posedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        check("burst_reset_dout", bus.DOut, 64'h0);
        tick();
        check("reset_ignores_clk", bus.DOut, 64'h0);
        set_idle();
        Rst = 1'b1;
        do_read(ONES128, 1'b0, '0);
        check("burst_array_clear", bus.DOut, 64'h0);
        do_read(ONES128, 1'b1, 128'h1);
        check("burst_compute_clear", bus.DOut, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
